// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_TAMANO_DEF = 8;
  localparam int DIV_CNT_W_DEF  = $clog2(DIV_TAMANO_DEF + 1);

  // Counter must hold the value tamano itself, hence +1.
  function automatic int div_cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring divider datapath: M/RR/QR registers, trial subtract, restore mux, Q/R outputs.
module div_datapath
  import div_pkg::*;
#(
  parameter int tamano = DIV_TAMANO_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_latch,
  input  logic              i_zero,
  input  logic [tamano-1:0] i_a,
  input  logic [tamano-1:0] i_b,
  output logic [tamano-1:0] o_q,
  output logic [tamano-1:0] o_r
);

  logic [tamano-1:0] r_m, r_qr, r_q, r_r;
  logic [tamano:0]   r_rr;
  logic [tamano:0]   w_sh, w_t, w_rr_nxt;
  logic [tamano-1:0] w_qr_nxt;
  logic              w_ok;

  // RR is one bit wider than M so the trial subtraction cannot overflow.
  assign w_sh     = {r_rr[tamano-1:0], r_qr[tamano-1]};
  assign w_t      = w_sh - {1'b0, r_m};
  assign w_ok     = ~w_t[tamano];
  assign w_rr_nxt = w_ok ? w_t : w_sh;
  assign w_qr_nxt = {r_qr[tamano-2:0], w_ok};

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_m  <= '0;
      r_qr <= '0;
      r_rr <= '0;
      r_q  <= '0;
      r_r  <= '0;
    end else begin
      if (i_load) begin
        r_m  <= i_b;
        r_qr <= i_a;
        r_rr <= '0;
      end else if (i_step) begin
        r_rr <= w_rr_nxt;
        r_qr <= w_qr_nxt;
      end
      // Latch captures the result of the final step in the same edge.
      if (i_latch) begin
        r_q <= w_qr_nxt;
        r_r <= w_rr_nxt[tamano-1:0];
      end else if (i_zero) begin
        r_q <= '1;
        r_r <= i_a;
      end
    end
  end

  assign o_q = r_q;
  assign o_r = r_r;

endmodule

// File: rtl/divider_restoring.sv
// Sequential unsigned restoring divider: FSM and bit counter, one quotient bit per clock.
module divider_restoring
  import div_pkg::*;
#(
  parameter int tamano = DIV_TAMANO_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [tamano-1:0] A,
  input  logic [tamano-1:0] B,
  output logic [tamano-1:0] Q,
  output logic [tamano-1:0] R,
  output logic              BUSY,
  output logic              END_DIV,
  output logic              DIV_ZERO
);

  localparam int CW = div_cnt_w(tamano);

  div_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_end, r_dz;
  logic          w_load, w_step, w_latch, w_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_latch     = 1'b0;
    w_zero      = 1'b0;
    case (r_state)
      IDLE: if (START) begin
        if (B != '0) begin
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end else begin
          w_zero      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_latch     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_end   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load)      r_cnt <= CW'(tamano);
      else if (w_step) r_cnt <= r_cnt - CW'(1);
      r_busy <= (w_state_nxt != IDLE);
      r_end  <= (w_state_nxt == DONE);
      if (w_load)      r_dz <= 1'b0;
      else if (w_zero) r_dz <= 1'b1;
    end
  end

  div_datapath #(.tamano(tamano)) u_dp (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_latch (w_latch),
    .i_zero  (w_zero),
    .i_a     (A),
    .i_b     (B),
    .o_q     (Q),
    .o_r     (R)
  );

  assign BUSY     = r_busy;
  assign END_DIV  = r_end;
  assign DIV_ZERO = r_dz;

endmodule

// File: tb/tb_divider_restoring.sv
// Self-checking bench for divider_restoring: vector table, handshake corners, random model check.
module tb_divider_restoring;

  localparam int W = 8;

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic         START = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] Q, R;
  logic         BUSY, END_DIV, DIV_ZERO;

  int checks = 0;
  int errors = 0;

  divider_restoring #(.tamano(W)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .START(START), .A(A), .B(B),
    .Q(Q), .R(R), .BUSY(BUSY), .END_DIV(END_DIV), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dz;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation; returns outputs seen on the END_DIV cycle, latency in cycles after acceptance.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output int lat, output int bcnt);
    int guard = 0;
    while (BUSY && guard < 40) begin @(negedge CLOCK); guard++; end
    A = a; B = b; START = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK);
    START = 1'b0;
    A = ~a; B = ~b;  // operands must already be captured
    lat  = 1;
    bcnt = BUSY ? 1 : 0;
    while (!END_DIV && lat < 40) begin
      @(negedge CLOCK);
      lat++;
      if (BUSY) bcnt++;
    end
    if (!END_DIV) begin
      checks++; errors++;
      $display("FAIL timeout: no END_DIV for A=%0d B=%0d", a, b);
    end
    q = Q; r = R; dz = DIV_ZERO;
  endtask

  initial begin
    vec_t         tbl[6];
    logic [W-1:0] q, r, ea, eb;
    logic         dz;
    int           lat, bcnt, n, seen;

    tbl[0] = '{a:100, b:7,   q:14,  r:2,   dz:0, lat:9};
    tbl[1] = '{a:255, b:1,   q:255, r:0,   dz:0, lat:9};
    tbl[2] = '{a:5,   b:9,   q:0,   r:5,   dz:0, lat:9};
    tbl[3] = '{a:255, b:255, q:1,   r:0,   dz:0, lat:9};
    tbl[4] = '{a:200, b:0,   q:255, r:200, dz:1, lat:1};
    tbl[5] = '{a:9,   b:3,   q:3,   r:0,   dz:0, lat:9};

    repeat (3) @(negedge CLOCK);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("reset_q", Q, 0);
    chk("reset_r", R, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_end", END_DIV, 0);
    chk("reset_dz", DIV_ZERO, 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, q, r, dz, lat, bcnt);
      chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      chk($sformatf("tbl%0d_r", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_dz", i), dz, tbl[i].dz);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_busy", i), bcnt, tbl[i].lat);
    end
    @(negedge CLOCK);
    chk("end_pulse_single", END_DIV, 0);
    chk("hold_q", Q, 3);

    // START held high; A changes mid-calculation and feeds the second operation.
    while (BUSY) @(negedge CLOCK);
    A = 50; B = 6; START = 1'b1;
    @(posedge CLOCK);
    n = 0; seen = 0;
    while (seen < 2 && n < 40) begin
      @(negedge CLOCK);
      n++;
      if (n == 3) A = 77;
      if (END_DIV) begin
        seen++;
        if (seen == 1) begin
          chk("b2b_lat1", n, 9);
          chk("b2b_q1", Q, 8);
          chk("b2b_r1", R, 2);
        end else begin
          START = 1'b0;
          chk("b2b_lat2", n, 19);
          chk("b2b_q2", Q, 12);
          chk("b2b_r2", R, 5);
        end
      end
      if (n == 10) chk("b2b_idle_gap", BUSY, 0);
    end
    chk("b2b_seen", seen, 2);
    START = 1'b0;

    // Asynchronous reset in the 4th CALC cycle.
    while (BUSY) @(negedge CLOCK);
    A = 100; B = 7; START = 1'b1;
    @(posedge CLOCK);
    @(negedge CLOCK); START = 1'b0;
    repeat (3) @(negedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    chk("arst_q", Q, 0);
    chk("arst_r", R, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_end", END_DIV, 0);
    chk("arst_dz", DIV_ZERO, 0);
    @(negedge CLOCK); RESET = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge CLOCK); if (END_DIV || BUSY) seen++; end
    chk("arst_no_end", seen, 0);
    run_op(100, 7, q, r, dz, lat, bcnt);
    chk("arst_after_q", q, 14);
    chk("arst_after_r", r, 2);
    chk("arst_after_lat", lat, 9);

    // Randomized operands against plain integer division.
    for (int k = 0; k < 1000; k++) begin
      ea = W'($urandom_range(0, 255));
      eb = (k % 50 == 0) ? '0 : W'($urandom_range(0, 255));
      run_op(ea, eb, q, r, dz, lat, bcnt);
      if (eb == 0) begin
        chk("rnd_dz_q", q, 255);
        chk("rnd_dz_r", r, ea);
        chk("rnd_dz_flag", dz, 1);
      end else begin
        chk($sformatf("rnd_q %0d/%0d", ea, eb), q, ea / eb);
        chk($sformatf("rnd_r %0d/%0d", ea, eb), r, ea % eb);
        chk("rnd_identity", int'(q) * int'(eb) + int'(r), ea);
        chk("rnd_r_lt_b", (r < eb) ? 1 : 0, 1);
        chk("rnd_dz_clr", dz, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
